lenet_mul_sched: RTL

Round-robin scheduler that time-shares one combinational 8x8 unsigned multiplier core among `NREQ` requesters in the LeNet inference datapath. Each requester presents operand pairs over a valid/ready handshake. The block arbitrates once per cycle and registers the winner's operands into a two-stage pipeline around the core. It returns each 16-bit product on a single result port tagged with requester id and user tag, with full backpressure.

---
 rtl/lenet_mul_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/lenet_mul_sched.sv | 123 ++++++++++++
 3 files changed

// File: rtl/lenet_mul_pkg.sv
// Shared widths, the result record and the round-robin pointer step.
package lenet_mul_pkg;
  localparam int MUL_W    = 8;
  localparam int PROD_W   = 16;
  localparam int RES_IDW  = 3;   // wide enough for NREQ up to 8
  localparam int RES_TAGW = 16;  // widest supported user tag

  typedef struct packed {
    logic [PROD_W-1:0]   z;
    logic [RES_IDW-1:0]  id;
    logic [RES_TAGW-1:0] tag;
  } res_t;

  function automatic int unsigned rr_next(input int unsigned g, input int unsigned n);
    return (g + 1 >= n) ? 0 : g + 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first requester at or after ptr, with wrap.
// No state; the pointer register lives in the parent.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [IW-1:0] ptr,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          found
);
  logic [IW-1:0] j;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int k = 0; k < N; k++) begin
      j = IW'((int'(ptr) + k) % N);
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end
endmodule

// File: rtl/lenet_mul_sched.sv
// Shared 8x8 multiplier core plus the round-robin scheduler around it.
// Latency 2 cycles; res_ready low stalls S2, then S1, then drops req_ready.
module lenet_mul_core
  import lenet_mul_pkg::*;
#(
  parameter bit APPROX = 1'b0
) (
  input  logic [MUL_W-1:0]  a,
  input  logic [MUL_W-1:0]  b,
  output logic [PROD_W-1:0] p
);
  if (APPROX) begin : g_approx
    // Drop the two low operand bits; same ports, cheaper partial-product array.
    logic [MUL_W-1:0] at, bt;
    assign at = {a[MUL_W-1:2], 2'b00};
    assign bt = {b[MUL_W-1:2], 2'b00};
    assign p  = PROD_W'(at) * PROD_W'(bt);
  end else begin : g_exact
    assign p = PROD_W'(a) * PROD_W'(b);
  end
endmodule

module lenet_mul_sched
  import lenet_mul_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int TAGW   = 4,
  parameter int IDW    = $clog2(NREQ),
  parameter bit APPROX = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*8-1:0]    req_x,
  input  logic [NREQ*8-1:0]    req_y,
  input  logic [NREQ*TAGW-1:0] req_tag,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [PROD_W-1:0]    res_z,
  output logic [IDW-1:0]       res_id,
  output logic [TAGW-1:0]      res_tag,
  output logic [31:0]          op_count,
  output logic                 busy
);
  logic [IDW-1:0]    ptr, gidx;
  logic [NREQ-1:0]   grant;
  logic              any_req, adv1, adv2, hs;
  logic              v1, v2;
  logic [MUL_W-1:0]  x1, y1;
  logic [IDW-1:0]    id1;
  logic [TAGW-1:0]   tag1;
  logic [PROD_W-1:0] prod;
  res_t              s2;
  logic [31:0]       cnt;

  rr_arbiter #(.N(NREQ), .IW(IDW)) u_arb (
    .ptr   (ptr),
    .req   (req_valid),
    .grant (grant),
    .idx   (gidx),
    .found (any_req)
  );

  lenet_mul_core #(.APPROX(APPROX)) u_core (
    .a (x1),
    .b (y1),
    .p (prod)
  );

  assign adv2      = !v2 || res_ready;
  assign adv1      = !v1 || adv2;
  assign hs        = any_req && adv1;
  assign req_ready = adv1 ? grant : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr  <= '0;
      v1   <= 1'b0;
      x1   <= '0;
      y1   <= '0;
      id1  <= '0;
      tag1 <= '0;
      v2   <= 1'b0;
      s2   <= '0;
      cnt  <= '0;
    end else begin
      if (adv2) begin
        v2 <= v1;
        // Result data only moves with a real entry, so idle outputs stay put.
        if (v1) begin
          s2.z   <= prod;
          s2.id  <= RES_IDW'(id1);
          s2.tag <= RES_TAGW'(tag1);
        end
      end
      if (adv1) begin
        v1 <= hs;
        if (hs) begin
          x1   <= req_x[gidx*MUL_W +: MUL_W];
          y1   <= req_y[gidx*MUL_W +: MUL_W];
          id1  <= gidx;
          tag1 <= req_tag[gidx*TAGW +: TAGW];
        end
      end
      if (hs) begin
        ptr <= IDW'(rr_next(32'(gidx), NREQ));
        cnt <= cnt + 32'd1;
      end
    end
  end

  // Upper record bits exist only for the widest parameterisation.
  logic unused_res_hi;
  assign unused_res_hi = ^{s2.id, s2.tag};

  assign res_valid = v2;
  assign res_z     = s2.z;
  assign res_id    = s2.id[IDW-1:0];
  assign res_tag   = s2.tag[TAGW-1:0];
  assign op_count  = cnt;
  assign busy      = v1 || v2;
endmodule
